rand_note_gen: RTL
==================

RAND_NOTE_GEN -- requirements
Module: rand_note_gen

Interface
REQ-001 The module SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Parameter WIDTH, default 16, SHALL set the LFSR register width; legal range 4..32.
REQ-003 Parameter TAPS, default 16'hB400, SHALL be a WIDTH-bit feedback tap mask.
REQ-004 Parameter SEED_DEFAULT, default 1, SHALL be the nonzero reset and zero-substitute LFSR value.
REQ-005 Parameter NOTE_BITS, default 4, SHALL set the note width, with NOTE_BITS <= WIDTH.
REQ-006 Parameter NUM_NOTES, default 12, SHALL bound note values to 0..NUM_NOTES-1, with NUM_NOTES <= 2**NOTE_BITS.
REQ-007 Parameter MAX_TRIES, default 8, SHALL cap rejected draws per request; minimum 1.
REQ-008 Port clk, input, 1 bit: rising-edge clock.
REQ-009 Port reset, input, 1 bit: asynchronous active-low reset.
REQ-010 Port free_run, input, 1 bit: 1 advances the LFSR every cycle in IDLE.
REQ-011 Port no_repeat, input, 1 bit: 1 forbids a note equal to the previously delivered note.
REQ-012 Port seed_load, input, 1 bit: loads seed_in into the LFSR.
REQ-013 Port seed_in, input, WIDTH bits: seed value.
REQ-014 Port req, input, 1 bit: level request for one note, sampled in IDLE.
REQ-015 Port note_ready, input, 1 bit: consumer accepts the note.
REQ-016 Port note, output, NOTE_BITS bits: delivered note.
REQ-017 Port note_valid, output, 1 bit: note is valid.
REQ-018 Port busy, output, 1 bit: high in DRAW.
REQ-019 Port lfsr_state, output, WIDTH bits: current LFSR register.

Function
REQ-020 The LFSR SHALL be Fibonacci: fb = XOR of state bits where TAPS=1; next = {state[WIDTH-2:0], fb}.
REQ-021 The LFSR SHALL advance every cycle in DRAW, in IDLE only when free_run=1, and never in HOLD.
REQ-022 seed_load SHALL override stepping in any state; seed_in=0 SHALL load SEED_DEFAULT; draw progress is unaffected.
REQ-023 The FSM SHALL have states IDLE, DRAW, and HOLD; IDLE->DRAW when req=1; HOLD->IDLE when note_ready=1; req in DRAW or HOLD is ignored.
REQ-024 In DRAW: cand = lfsr_state[NOTE_BITS-1:0]; reject if cand >= NUM_NOTES, or if no_repeat=1, has_last=1, and cand == last_note.
REQ-025 On rejection with tries < MAX_TRIES, the block SHALL increment tries and remain in DRAW.
REQ-026 When tries == MAX_TRIES, the block SHALL force c = cand % NUM_NOTES, then c = (c+1) % NUM_NOTES if the repeat rule hits; c is accepted.
REQ-027 On accept, at the next edge: note<=c, last_note<=c, has_last<=1, note_valid<=1, tries<=0, go to HOLD.
REQ-028 Latency SHALL be: req sampled at edge k gives note_valid at edge k+1+(number of rejects).
REQ-029 In HOLD, note and note_valid SHALL hold stable until the edge where note_ready=1, then note_valid<=0.
REQ-030 note_ready while note_valid=0 SHALL be ignored.
REQ-031 The first note after reset SHALL ignore no_repeat (has_last=0).
REQ-032 An all-zero LFSR SHALL be unreachable; if detected, the block SHALL load SEED_DEFAULT on the next edge.

Reset
REQ-033 reset=0 SHALL immediately force: lfsr=SEED_DEFAULT, state IDLE, note=0, note_valid=0, busy=0, tries=0, last_note=0, has_last=0.
REQ-034 Reset mid-DRAW or mid-HOLD SHALL abort the draw with no note delivered; operation resumes on the first edge after reset=1.

Verification
All scenarios use WIDTH=4, TAPS=4'b1100, SEED_DEFAULT=1, NOTE_BITS=4, NUM_NOTES=12, MAX_TRIES=2, free_run=0. The LFSR sequence from seed 1 is 1,2,4,9,3,6,13,10,5,11,7,15,14,12,8.
REQ-035 Reset, then req=1 for one cycle with note_ready=1 -> note=1 and note_valid for one cycle; second req -> note=2.
REQ-036 seed_load 13, then req -> 13 rejected, note=10, note_valid two cycles after req, busy high for 2 cycles.
REQ-037 seed_load 15, then req -> 15 and 14 rejected, forced 12%12 -> note=0 on the third DRAW cycle.
REQ-038 seed_load 9, req -> note 9; seed_load 9 again, no_repeat=1, req -> note=3; seed_load 0 -> lfsr_state=1.
REQ-039 note_ready=0 for 5 cycles in HOLD -> note and lfsr_state stable, extra req ignored; reset mid-DRAW -> note_valid=0 and lfsr_state=1 immediately.

Source files
------------

// File: rtl/rand_note_gen.sv
`default_nettype none
// ============================================================================
//  Module      : rand_note_gen
//  Description : LFSR-driven random note generator. A request triggers a
//                bounded rejection-sampling draw of a note in
//                0..NUM_NOTES-1, optionally excluding the previously
//                delivered note, with a valid/ready style hand-off.
//  Revision    : 1.0 - initial release
// ============================================================================
module rand_note_gen #(
  parameter int unsigned      WIDTH        = 16,
  parameter logic [WIDTH-1:0] TAPS         = 16'hB400,
  parameter logic [WIDTH-1:0] SEED_DEFAULT = {{(WIDTH-1){1'b0}}, 1'b1},
  parameter int unsigned      NOTE_BITS    = 4,
  parameter int unsigned      NUM_NOTES    = 12,
  parameter int unsigned      MAX_TRIES    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 free_run,
  input  logic                 no_repeat,
  input  logic                 seed_load,
  input  logic [WIDTH-1:0]     seed_in,
  input  logic                 req,
  input  logic                 note_ready,
  output logic [NOTE_BITS-1:0] note,
  output logic                 note_valid,
  output logic                 busy,
  output logic [WIDTH-1:0]     lfsr_state
);

  // Tries counter must be able to hold MAX_TRIES itself.
  localparam int unsigned TRY_W = (MAX_TRIES < 1) ? 1 : $clog2(MAX_TRIES + 1);
  // One extra bit so NUM_NOTES == 2**NOTE_BITS is representable.
  localparam int unsigned CMP_W = NOTE_BITS + 1;

  localparam logic [CMP_W-1:0] C_NUM_NOTES = CMP_W'(NUM_NOTES);
  localparam logic [TRY_W-1:0] C_MAX_TRIES = TRY_W'(MAX_TRIES);
  localparam logic [TRY_W-1:0] C_TRY_ONE   = TRY_W'(1);
  localparam logic [CMP_W-1:0] C_CMP_ONE   = CMP_W'(1);
  localparam logic [WIDTH-1:0] C_LFSR_ZERO = '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DRAW = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t               r_state;
  logic [WIDTH-1:0]     r_lfsr;
  logic [NOTE_BITS-1:0] r_note;
  logic                 r_note_valid;
  logic                 r_busy;
  logic [TRY_W-1:0]     r_tries;
  logic [NOTE_BITS-1:0] r_last_note;
  logic                 r_has_last;

  logic                 w_feedback;
  logic [WIDTH-1:0]     w_lfsr_step;
  logic                 w_lfsr_advance;
  logic [NOTE_BITS-1:0] w_cand;
  logic [CMP_W-1:0]     w_cand_ext;
  logic                 w_out_of_range;
  logic                 w_repeat_hit;
  logic                 w_reject;
  logic                 w_forced;
  logic [CMP_W-1:0]     w_mod_ext;
  logic [CMP_W-1:0]     w_mod_inc;
  logic [NOTE_BITS-1:0] w_mod_note;
  logic [NOTE_BITS-1:0] w_mod_next;
  logic                 w_mod_repeat;
  logic [NOTE_BITS-1:0] w_forced_note;
  logic                 w_accept;
  logic [NOTE_BITS-1:0] w_choice;

  // Fibonacci LFSR next value and the condition under which it steps.
  always_comb begin
    w_feedback     = ^(r_lfsr & TAPS);
    w_lfsr_step    = {r_lfsr[WIDTH-2:0], w_feedback};
    w_lfsr_advance = (r_state == ST_DRAW) || ((r_state == ST_IDLE) && free_run);
  end

  // Candidate evaluation: range/repeat rejection and the forced fallback once
  // the retry budget is exhausted.
  always_comb begin
    w_cand         = r_lfsr[NOTE_BITS-1:0];
    w_cand_ext     = {1'b0, w_cand};
    w_out_of_range = (w_cand_ext >= C_NUM_NOTES);
    w_repeat_hit   = no_repeat && r_has_last && (w_cand == r_last_note);
    w_reject       = w_out_of_range || w_repeat_hit;
    w_forced       = (r_tries >= C_MAX_TRIES);

    // Fold the candidate into range, then step past the last note if needed.
    w_mod_ext      = w_cand_ext % C_NUM_NOTES;
    w_mod_note     = w_mod_ext[NOTE_BITS-1:0];
    w_mod_inc      = w_mod_ext + C_CMP_ONE;
    if (w_mod_inc >= C_NUM_NOTES) begin
      w_mod_next = '0;
    end else begin
      w_mod_next = w_mod_inc[NOTE_BITS-1:0];
    end
    w_mod_repeat   = no_repeat && r_has_last && (w_mod_note == r_last_note);
    w_forced_note  = w_mod_repeat ? w_mod_next : w_mod_note;

    w_accept       = w_forced || !w_reject;
    w_choice       = w_forced ? w_forced_note : w_cand;
  end

  // LFSR register: seed load wins, a stuck-at-zero value self-heals,
  // otherwise step when the FSM allows it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lfsr <= SEED_DEFAULT;
    end else if (seed_load) begin
      r_lfsr <= (seed_in == C_LFSR_ZERO) ? SEED_DEFAULT : seed_in;
    end else if (r_lfsr == C_LFSR_ZERO) begin
      r_lfsr <= SEED_DEFAULT;
    end else if (w_lfsr_advance) begin
      r_lfsr <= w_lfsr_step;
    end
  end

  // Control FSM with registered note/valid/busy outputs and draw bookkeeping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_note       <= '0;
      r_note_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_tries      <= '0;
      r_last_note  <= '0;
      r_has_last   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req) begin
            r_state <= ST_DRAW;
            r_busy  <= 1'b1;
            r_tries <= '0;
          end
        end

        ST_DRAW: begin
          if (w_accept) begin
            r_note       <= w_choice;
            r_last_note  <= w_choice;
            r_has_last   <= 1'b1;
            r_note_valid <= 1'b1;
            r_tries      <= '0;
            r_busy       <= 1'b0;
            r_state      <= ST_HOLD;
          end else begin
            r_tries <= r_tries + C_TRY_ONE;
          end
        end

        ST_HOLD: begin
          // Note and valid stay frozen until the consumer takes the note.
          if (note_ready) begin
            r_note_valid <= 1'b0;
            r_state      <= ST_IDLE;
          end
        end

        default: begin
          r_state      <= ST_IDLE;
          r_busy       <= 1'b0;
          r_note_valid <= 1'b0;
          r_tries      <= '0;
        end
      endcase
    end
  end

  assign note       = r_note;
  assign note_valid = r_note_valid;
  assign busy       = r_busy;
  assign lfsr_state = r_lfsr;

endmodule
`default_nettype wire
